instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front-end producer for the decode stage: holds the program counter, issues word reads to instruction memory over a request/grant/response handshake, and delivers `{pc, instr}` pairs to `instruction_decoder` through a small buffer with a valid/ready handshake. A redirect input (branch/jump/exception target) flushes all buffered and in-flight fetches and restarts at the new PC. It sits between the instruction memory port and the decode unit.

## Interface
- `XLEN`, 32: address and instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: buffer entries toward decode. Legal values are 2 or 4.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request. Held until granted or cancelled by redirect.
- `imem_addr`  out  XLEN  word-aligned fetch address. Stable while `imem_req`=1.
- `imem_gnt`  in  1  memory accepted request this cycle.
- `imem_rvalid`  in  1  read data valid. Exactly one per grant, at least 1 cycle after the grant.
- `imem_rdata`  in  XLEN  instruction word.
- `redirect_valid`  in  1  one-cycle pulse: restart fetch.
- `redirect_pc`  in  XLEN  new PC. Bits [1:0] are ignored and forced to 0.
- `instr_valid`  out  1  buffer head is valid.
- `instr_ready`  in  1  decoder accepts head this cycle.
- `instr`  out  XLEN  head instruction.
- `instr_pc`  out  XLEN  PC of head instruction.

## Operation
- **Outstanding requests:** at most one memory request is outstanding (granted, no rvalid yet).
- **Issue credit:** a new request issues only if `count + outstanding < DEPTH`, where `count` is buffer occupancy.
- **FSM states:**
  - **IDLE:** `imem_req`=0. Goes to REQ when credit is available and no redirect.
  - **REQ:** `imem_req`=1, `imem_addr`=fetch_pc.
    - On `imem_gnt`: go to WAIT and set fetch_pc += 4 (wraps modulo 2^XLEN).
  - **WAIT:** on `imem_rvalid`, push `{issued_pc, imem_rdata}` into the buffer.
    - Go to REQ if credit remains after the push, else IDLE.
  - **DROP:** a killed request is in flight. On `imem_rvalid`, discard the data and go to REQ.
- **Redirect** has priority over every other event in the same cycle:
  - Flush the buffer (count=0), set fetch_pc=redirect_pc, clear issued_pc tracking.
  - REQ without a same-cycle gnt: cancel the request and go to REQ next cycle with the new address (`imem_req` stays 1, address changes).
  - REQ with a same-cycle gnt: go to DROP.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid: discard the data and go to REQ.
  - DROP: stay in DROP. A second redirect only updates fetch_pc.
  - IDLE: go to REQ.
  - A same-cycle `instr_ready` pop is ignored. The buffer is empty next cycle anyway.
- **Buffer:** FIFO ordering. Push and pop in the same cycle is legal, including when full (push is allowed only by credit) and when empty (no bypass; data appears the next cycle).
- **Output stability:** `instr`/`instr_pc` must not change while `instr_valid`=1 and `instr_ready`=0.

## Timing
- **Reset values (async assert, sync deassert by design):**
  - state=IDLE, fetch_pc=RESET_PC.
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0, count=0.
- **First request:** the first cycle after `rst_n` rises is IDLE. `imem_req`=1 with `imem_addr`=RESET_PC from the second cycle.
- **Fetch latency:** grant at cycle t, rvalid at t+k gives `instr_valid`=1 at t+k+1. The next request issues at t+k+1 if credit allows.
- **Redirect:** pulse at cycle r gives `instr_valid`=0 from r+1. `imem_addr`=redirect_pc from r+1 (or after the DROP rvalid).
- **Reset mid-operation:** an in-flight memory response arriving after reset is not tracked. The memory side is reset together with this block.

## Structure
- **Shared package `fetch_pkg`:** the state enum (IDLE/REQ/WAIT/DROP), XLEN default, a PC increment constant of 4, and the `fetch_entry_t` struct `{pc, instr}`.
- **Sub-module `fetch_fifo`:** parameterized depth, push/pop/count/flush, holds `fetch_entry_t`.
- **Top level:** the FSM, fetch_pc/issued_pc registers and credit logic.

## Test plan
- **Reset and streaming:** reset, gnt same cycle as req, rvalid 1 cycle later, `instr_ready`=1, memory returns addr^32'hA5A5_0000.
  - `instr_pc` sequence is 0, 4, 8, 12 with matching `instr`. No gaps beyond the fixed per-fetch latency.
- **Backpressure:** hold `instr_ready`=0 for 10 cycles.
  - Exactly DEPTH entries (PCs 0, 4) are buffered, then `imem_req` drops.
  - Head stays stable. On release, pops proceed in order and fetching resumes at PC 8.
- **Redirect while waiting:** `redirect_pc`=32'h0000_1002 while in WAIT.
  - The late rvalid data is discarded.
  - The next `imem_addr` is 32'h0000_1000 and the first delivered `instr_pc` is 32'h0000_1000.
- **Redirect colliding with grant:** redirect in REQ in the same cycle as `imem_gnt`.
  - Goes to DROP. One response is dropped. No stale instruction reaches decode.
  - A redirect in REQ without gnt changes the address with `imem_req` held high.
- **PC wraparound:** `redirect_pc`=32'hFFFF_FFFC.
  - Delivered PCs are FFFF_FFFC then 0000_0000.
- **Reset mid-stream:** assert `rst_n`=0 asynchronously with a full buffer.
  - All outputs go to their reset values immediately. Fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   - fetch_state_e : fetch FSM states (IDLE / REQ / WAIT / DROP)
//   - FETCH_XLEN    : default address / instruction width
//   - PC_INC        : byte increment between sequential fetches
//   - fetch_entry_t : one buffered {pc, instr} pair handed to decode
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [FETCH_XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetch_entry_t between the fetch FSM and decode.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : drop every entry (takes priority over push/pop)
//   push, push_pc,
//   push_instr        : write one entry at the tail
//   pop               : remove the head entry
//   head_pc,
//   head_instr        : current head entry (meaningful only when count != 0)
//   count             : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [FETCH_XLEN-1:0] push_pc,
    input  logic [FETCH_XLEN-1:0] push_instr,
    input  logic                  pop,
    output logic [FETCH_XLEN-1:0] head_pc,
    output logic [FETCH_XLEN-1:0] head_instr,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted when the head leaves in the same
    // cycle; there is no bypass, so a push into an empty FIFO shows up next cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is data only: it needs no reset because count gates its use.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
        end
    end

    assign head_pc    = mem[rd_ptr].pc;
    assign head_instr = mem[rd_ptr].instr;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the program counter, issues word reads
// to instruction memory (req/gnt/rvalid, at most one outstanding) and hands
// {pc, instr} pairs to decode through fetch_fifo (valid/ready).
// A redirect flushes everything buffered or in flight and restarts at the
// new (word-aligned) PC.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   imem_req, imem_addr        : read request and its word address
//   imem_gnt                   : memory accepted the request this cycle
//   imem_rvalid, imem_rdata    : read response, one per grant
//   redirect_valid, redirect_pc: one-cycle restart pulse and target
//   instr_valid, instr_ready   : handshake toward decode
//   instr, instr_pc            : head instruction and its PC
// XLEN must equal fetch_pkg::FETCH_XLEN, which sizes the buffered entries.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [XLEN-1:0] issued_pc_q;
    logic [XLEN-1:0] issued_pc_d;
    logic [XLEN-1:0] redirect_target;
    logic [CNT_W-1:0] count;
    logic [OCC_W-1:0] occ_after_push;
    logic            fifo_push;
    logic            fifo_pop;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_instr;
    logic            redirect_lsbs_unused;

    // Byte offset bits of the target are discarded.
    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_lsbs_unused = ^redirect_pc[1:0];

    assign instr_valid = (count != '0);

    // A pop in the same cycle as a redirect is meaningless: the flush wins.
    assign fifo_pop = instr_valid && instr_ready && !redirect_valid;

    // Occupancy once the response being pushed this cycle lands, accounting
    // for a simultaneous pop. Decides whether the next request may issue.
    assign occ_after_push = OCC_W'(count) + OCC_W'(1) - OCC_W'(fifo_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        fifo_push   = 1'b0;

        if (redirect_valid) begin
            fetch_pc_d  = redirect_target;
            issued_pc_d = '0;
            case (state_q)
                IDLE: state_d = REQ;
                // Without a grant the request is simply retargeted; with one,
                // the memory owes us a response that must be thrown away.
                REQ:  state_d = imem_gnt ? DROP : REQ;
                WAIT: state_d = imem_rvalid ? REQ : DROP;
                // If the killed response lands in this very cycle nothing is
                // left in flight, so waiting in DROP would never end.
                DROP: state_d = imem_rvalid ? REQ : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (count < CNT_W'(DEPTH)) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        state_d     = WAIT;
                        issued_pc_d = fetch_pc_q;
                        fetch_pc_d  = fetch_pc_q + PC_INC;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        fifo_push = 1'b1;
                        state_d   = (occ_after_push < OCC_W'(DEPTH)) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    // The buffer was flushed by the redirect, so credit exists.
                    if (imem_rvalid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (fifo_push),
        .push_pc    (issued_pc_q),
        .push_instr (imem_rdata),
        .pop        (fifo_pop),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (count)
    );

    assign imem_req  = (state_q == REQ);
    assign imem_addr = fetch_pc_q;

    // Head fields read as zero whenever nothing is valid (including reset).
    assign instr    = instr_valid ? head_instr : '0;
    assign instr_pc = instr_valid ? head_pc    : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instruction_fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // buffered : instructions decode has yet to accept
    // pending  : one memory access in flight; live = its data will be kept
    // exp_pc   : PC decode must see next; exp_fetch : next PC to be fetched
    int          buffered;
    bit          pending;
    bit          live;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    bit          prev_req_hold;
    logic [31:0] prev_addr;
    int          cyc = 0;
    logic [31:0] dq_pc[$];
    logic [31:0] dq_instr[$];
    int          dq_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("reset_imem_req", imem_req, 0);
            chk("reset_imem_addr", imem_addr, RESET_PC);
            chk("reset_instr_valid", instr_valid, 0);
            chk("reset_instr", instr, 0);
            chk("reset_instr_pc", instr_pc, 0);
            buffered      = 0;
            pending       = 0;
            live          = 0;
            exp_pc        = RESET_PC;
            exp_fetch     = RESET_PC;
            prev_req_hold = 0;
        end else begin
            chk("valid_vs_occupancy", instr_valid, buffered != 0);
            if (instr_valid) begin
                chk("head_pc", instr_pc, exp_pc);
                chk("head_instr", instr, memf(exp_pc));
            end
            if (prev_req_hold) begin
                chk("req_held", imem_req, 1);
                chk("addr_stable", imem_addr, prev_addr);
            end
            if (pending) chk("single_outstanding", imem_req, 0);
            if (imem_req && imem_gnt && !redirect_valid) begin
                chk("fetch_addr", imem_addr, exp_fetch);
                chk("issue_credit", buffered < DEPTH, 1);
            end
            prev_req_hold = imem_req && !imem_gnt && !redirect_valid;
            prev_addr     = imem_addr;

            if (redirect_valid) begin
                buffered  = 0;
                exp_pc    = {redirect_pc[31:2], 2'b00};
                exp_fetch = {redirect_pc[31:2], 2'b00};
                if (imem_rvalid) pending = 0;
                live = 0;
                if (imem_req && imem_gnt) pending = 1;
            end else begin
                if (imem_rvalid && pending) begin
                    if (live) buffered++;
                    pending = 0;
                end
                if (instr_valid && instr_ready) begin
                    dq_pc.push_back(instr_pc);
                    dq_instr.push_back(instr);
                    dq_cyc.push_back(cyc);
                    buffered--;
                    exp_pc = exp_pc + 32'd4;
                end
                if (imem_req && imem_gnt) begin
                    pending   = 1;
                    live      = 1;
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
    end

    // ---------------- memory model and stimulus ----------------
    int          gnt_pct   = 100;
    int          ready_pct = 100;
    int          lat_max   = 1;
    int          redir_pct = 0;
    bit          mem_pend  = 0;
    logic [31:0] mem_addr  = 0;
    int          mem_wait  = 0;

    task automatic step();
        logic        g;
        logic        rv;
        logic [31:0] a;
        @(negedge clk);
        g  = imem_req && imem_gnt;
        rv = imem_rvalid;
        a  = imem_addr;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mem_pend       = 0;
            imem_gnt       = 0;
            imem_rvalid    = 0;
            imem_rdata     = 0;
            redirect_valid = 0;
        end else begin
            if (rv) mem_pend = 0;
            if (g) begin
                mem_pend = 1;
                mem_addr = a;
                mem_wait = $urandom_range(0, lat_max - 1);
            end
            if (mem_pend && mem_wait == 0) begin
                imem_rvalid = 1;
                imem_rdata  = memf(mem_addr);
            end else begin
                imem_rvalid = 0;
                imem_rdata  = $urandom;
                if (mem_pend) mem_wait--;
            end
            imem_gnt       = imem_req && ($urandom_range(1, 100) <= gnt_pct);
            instr_ready    = ($urandom_range(1, 100) <= ready_pct);
            redirect_valid = 0;
            if (redir_pct > 0 && $urandom_range(1, 100) <= redir_pct) begin
                redirect_valid = 1;
                redirect_pc    = $urandom;
            end
        end
    endtask

    task automatic run_until_dq(input int n, input int budget, input string name);
        int k = 0;
        while (dq_pc.size() < n && k < budget) begin
            step();
            k++;
        end
        if (dq_pc.size() < n) chk({name, "_timeout"}, dq_pc.size(), n);
    endtask

    task automatic run_until_req(input int budget, input string name);
        int k = 0;
        while (!imem_req && k < budget) begin
            step();
            k++;
        end
        if (!imem_req) chk({name, "_timeout"}, imem_req, 1);
    endtask

    task automatic dq_expect(input int i, input logic [31:0] pc, input logic [31:0] ins,
                             input string name);
        if (i < dq_pc.size()) begin
            chk({name, "_pc"}, dq_pc[i], pc);
            chk({name, "_instr"}, dq_instr[i], ins);
        end else begin
            chk({name, "_missing"}, dq_pc.size(), i + 1);
        end
    endtask

    task automatic clear_dq();
        dq_pc.delete();
        dq_instr.delete();
        dq_cyc.delete();
    endtask

    task automatic do_reset(input int cycles);
        #1 rst_n = 0;
        repeat (cycles) step();
        rst_n = 1;
    endtask

    initial begin
        int k;
        int start_n;
        rst_n          = 0;
        imem_gnt       = 0;
        imem_rvalid    = 0;
        imem_rdata     = 0;
        redirect_valid = 0;
        redirect_pc    = 0;
        instr_ready    = 0;

        // Reset, then streaming with immediate grant and 1-cycle response.
        repeat (3) step();
        rst_n = 1;
        chk("first_cycle_idle", imem_req, 0);
        step();
        chk("second_cycle_req", imem_req, 1);
        chk("second_cycle_addr", imem_addr, RESET_PC);
        clear_dq();
        run_until_dq(4, 40, "stream");
        dq_expect(0, 32'h0000_0000, 32'hA5A5_0000, "stream0");
        dq_expect(1, 32'h0000_0004, 32'hA5A5_0004, "stream1");
        dq_expect(2, 32'h0000_0008, 32'hA5A5_0008, "stream2");
        dq_expect(3, 32'h0000_000C, 32'hA5A5_000C, "stream3");
        if (dq_cyc.size() >= 4)
            for (int i = 0; i < 3; i++) chk("stream_gap", dq_cyc[i+1] - dq_cyc[i], 2);

        // Backpressure from a fresh start: exactly DEPTH entries, then idle.
        ready_pct = 0;
        do_reset(2);
        repeat (12) step();
        chk("bp_valid", instr_valid, 1);
        chk("bp_head_pc", instr_pc, 32'h0000_0000);
        chk("bp_req_dropped", imem_req, 0);
        chk("bp_model_occupancy", buffered, 2);
        clear_dq();
        ready_pct = 100;
        run_until_dq(3, 40, "bp_release");
        dq_expect(0, 32'h0000_0000, 32'hA5A5_0000, "bp_pop0");
        dq_expect(1, 32'h0000_0004, 32'hA5A5_0004, "bp_pop1");
        dq_expect(2, 32'h0000_0008, 32'hA5A5_0008, "bp_pop2");

        // Redirect while a response is still owed (WAIT, no rvalid).
        lat_max = 4;
        k = 0;
        while (!(pending && !imem_rvalid && mem_wait > 0) && k < 200) begin
            step();
            k++;
        end
        chk("wait_found", pending && !imem_rvalid, 1);
        redirect_valid = 1;
        redirect_pc    = 32'h0000_1002;
        clear_dq();
        step();
        chk("redir_wait_valid_low", instr_valid, 0);
        run_until_req(20, "redir_wait_req");
        chk("redir_wait_addr", imem_addr, 32'h0000_1000);
        run_until_dq(1, 60, "redir_wait");
        dq_expect(0, 32'h0000_1000, 32'hA5A5_1000, "redir_wait_first");

        // Redirect colliding with a grant: one response must be dropped.
        lat_max = 2;
        run_until_req(40, "collide_req");
        imem_gnt       = 1;
        redirect_valid = 1;
        redirect_pc    = 32'h0000_2000;
        clear_dq();
        step();
        chk("collide_drop_no_req", imem_req, 0);
        chk("collide_valid_low", instr_valid, 0);
        run_until_dq(2, 60, "collide");
        dq_expect(0, 32'h0000_2000, 32'hA5A5_2000, "collide_first");
        dq_expect(1, 32'h0000_2004, 32'hA5A5_2004, "collide_second");

        // Redirect in REQ without grant: address changes, request stays high.
        run_until_req(40, "retarget_req");
        imem_gnt       = 0;
        redirect_valid = 1;
        redirect_pc    = 32'h0000_3000;
        step();
        chk("retarget_req_held", imem_req, 1);
        chk("retarget_addr", imem_addr, 32'h0000_3000);

        // PC wraparound.
        run_until_req(40, "wrap_req");
        imem_gnt       = 0;
        redirect_valid = 1;
        redirect_pc    = 32'hFFFF_FFFC;
        clear_dq();
        step();
        run_until_dq(2, 60, "wrap");
        dq_expect(0, 32'hFFFF_FFFC, 32'h5A5A_FFFC, "wrap_first");
        dq_expect(1, 32'h0000_0000, 32'hA5A5_0000, "wrap_second");

        // Asynchronous reset with a full buffer.
        ready_pct = 0;
        repeat (16) step();
        chk("midrst_full_valid", instr_valid, 1);
        #1 rst_n = 0;
        #1;
        chk("midrst_req", imem_req, 0);
        chk("midrst_addr", imem_addr, RESET_PC);
        chk("midrst_valid", instr_valid, 0);
        chk("midrst_instr", instr, 0);
        chk("midrst_pc", instr_pc, 0);
        repeat (2) step();
        ready_pct = 100;
        lat_max   = 1;
        rst_n     = 1;
        chk("midrst_first_idle", imem_req, 0);
        step();
        chk("midrst_restart_req", imem_req, 1);
        chk("midrst_restart_addr", imem_addr, RESET_PC);
        clear_dq();
        run_until_dq(2, 40, "midrst");
        dq_expect(0, 32'h0000_0000, 32'hA5A5_0000, "midrst_first");
        dq_expect(1, 32'h0000_0004, 32'hA5A5_0004, "midrst_second");

        // Randomized traffic checked every cycle by the model.
        gnt_pct   = 60;
        ready_pct = 70;
        lat_max   = 3;
        redir_pct = 4;
        start_n   = dq_pc.size();
        repeat (4000) step();
        chk("random_progress", dq_pc.size() - start_n > 200, 1);
        redir_pct = 0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
